// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED fade driver.
// Defaults describe the board build: 4 LEDs on a 50 MHz clock.
package led_pkg;

  localparam int unsigned LED_CH          = 4;
  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned PWM_BITS_DEF    = 8;
  localparam int unsigned DECAY_TICKS_DEF = 196_078;
  localparam int unsigned DECAY_STEP_DEF  = 8;

  // Saturating subtract: never wraps below zero.
  function automatic int unsigned sat_sub(int unsigned a, int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / LED-out signal group of the fade driver.
// The master drives enable and the raw pattern; the slave returns pins and sync.
interface led_fade_if
  import led_pkg::*;
#(
  parameter int unsigned CH = LED_CH
);

  logic          en;
  logic [CH-1:0] pat_in;
  logic [CH-1:0] led_out;
  logic          pwm_sync;

  modport master (output en, output pat_in, input led_out, input pwm_sync);
  modport slave  (input en, input pat_in, output led_out, output pwm_sync);

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with stepwise decay, period-aligned duty
// and the PWM compare that produces the raw (active-high) drive.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                bit_i,
  input  logic                tick_i,
  input  logic                wrap_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_raw_o
);

  localparam logic [PWM_BITS-1:0] MaxL = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (!en_i) begin
      level_d = '0;
    end else if (bit_i) begin
      level_d = MaxL;
    end else if (tick_i) begin
      level_d = PWM_BITS'(sat_sub(32'(level_q), DECAY_STEP));
    end
  end

  // Duty only changes at the period boundary so a period never sees two levels.
  always_comb begin
    duty_d = wrap_i ? level_q : duty_q;
    led_d  = en_i && (pwm_cnt_i < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      duty_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
    end
  end

  assign led_raw_o = led_q;

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade driver behind the LED chaser: lit bits drive full brightness,
// dropped bits fade out in DECAY_STEP decrements every DECAY_TICKS clocks.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned CH          = LED_CH,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
  parameter int unsigned DECAY_TICKS = DECAY_TICKS_DEF,
  parameter int unsigned DECAY_STEP  = DECAY_STEP_DEF,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  led_fade_if.slave bus
);

  localparam int unsigned         DcW      = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [DcW-1:0]      TickLast = DcW'(DECAY_TICKS - 1);
  // Period is MAXL = 2**PWM_BITS-1 clocks, so the counter's last value is MAXL-1.
  localparam logic [PWM_BITS-1:0] CntLast  = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DcW-1:0]      decay_cnt_q, decay_cnt_d;
  logic [CH-1:0]       pat_q;
  logic                pwm_sync_q, pwm_sync_d;
  logic                wrap, tick;
  logic [CH-1:0]       led_raw;

  always_comb begin
    wrap        = (pwm_cnt_q == CntLast);
    tick        = (decay_cnt_q == TickLast);
    pwm_cnt_d   = wrap ? '0 : pwm_cnt_q + 1'b1;
    decay_cnt_d = tick ? '0 : decay_cnt_q + 1'b1;
    pwm_sync_d  = (pwm_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
      pat_q       <= '0;
      pwm_sync_q  <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      pat_q       <= bus.pat_in;
      pwm_sync_q  <= pwm_sync_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (bus.en),
      .bit_i    (pat_q[i]),
      .tick_i   (tick),
      .wrap_i   (wrap),
      .pwm_cnt_i(pwm_cnt_q),
      .led_raw_o(led_raw[i])
    );
  end

  assign bus.led_out  = led_raw ^ {CH{ACTIVE_LOW}};
  assign bus.pwm_sync = pwm_sync_q;

endmodule
